// File: rtl/core_pkg.sv
// Shared definitions for the dispatch operand stage: default widths and the
// micro-op record carried by each execution-unit output slot.
// Ports: none (package).
package core_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int PREG_W_DEF  = 6;
  localparam int ROB_W_DEF   = 5;
  localparam int OPC_W_DEF   = 7;
  localparam int CNT_W_DEF   = 16;
  localparam int LUI_OPC_DEF = 0;  // LUI executes as ADD with a zero operand A

  // Micro-op as held in a unit slot, at the default widths. The top level
  // rebuilds the same layout at its own parameter widths.
  typedef struct packed {
    logic [XLEN_DEF-1:0]   a;
    logic [XLEN_DEF-1:0]   b;
    logic [OPC_W_DEF-1:0]  opc;
    logic [ROB_W_DEF-1:0]  rob;
    logic [PREG_W_DEF-1:0] dest;
  } dispatch_uop_t;

endpackage

// File: rtl/dispatch_slot.sv
// One execution-unit output register with valid/ready handshake.
// Latency: load visible one cycle after accept; holds contents while !consume.
// Ports: clk/rst_n, flush, load+uop_in, consume, req, uop_out/valid/free, stall_cnt.
module dispatch_slot #(
  parameter type uop_t = core_pkg::dispatch_uop_t,
  parameter int  CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  uop_t             uop_in,
  input  logic             consume,
  input  logic             req,
  output uop_t             uop_out,
  output logic             valid,
  output logic             free,
  output logic [CNT_W-1:0] stall_cnt
);

  assign free = !valid | consume;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      uop_out   <= '0;
      stall_cnt <= '0;
    end else begin
      // Flush wins; a load while the old op is consumed keeps valid high.
      if (flush)        valid <= 1'b0;
      else if (load)    valid <= 1'b1;
      else if (consume) valid <= 1'b0;

      if (load) uop_out <= uop_in;

      // Only counts cycles where upstream really wanted this slot.
      if (req && !free && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dispatch_operand_stage.sv
// Register-read / dispatch stage: forms operands and steers each micro-op
// into one of NUM_UNITS output slots; 1-cycle latency, ready_o drops on flush
// or when the target slot is occupied and not being consumed.
module dispatch_operand_stage
  import core_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int PREG_W    = PREG_W_DEF,
  parameter int ROB_W     = ROB_W_DEF,
  parameter int OPC_W     = OPC_W_DEF,
  parameter int NUM_UNITS = 2,
  parameter int LUI_OPC   = LUI_OPC_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  localparam int UNIT_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                        cpu_clock_i,
  input  logic                        cpu_reset_ni,
  input  logic                        flush_i,
  input  logic [ROB_W+2*PREG_W:0]     data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [ROB_W-1:0]            rob_o,
  output logic [PREG_W-1:0]           rs1_o,
  output logic [PREG_W-1:0]           rs2_o,
  input  logic [XLEN-1:0]             rs1_data_i,
  input  logic [XLEN-1:0]             rs2_data_i,
  input  logic [OPC_W-1:0]            opcode_i,
  input  logic                        imm_i,
  input  logic [XLEN-1:0]             immediate_i,
  input  logic [PREG_W-1:0]           dest_i,
  input  logic                        lui_i,
  input  logic [UNIT_W-1:0]           unit_i,
  output logic [NUM_UNITS*XLEN-1:0]   unit_a_o,
  output logic [NUM_UNITS*XLEN-1:0]   unit_b_o,
  output logic [NUM_UNITS*OPC_W-1:0]  unit_opc_o,
  output logic [NUM_UNITS*ROB_W-1:0]  unit_rob_o,
  output logic [NUM_UNITS*PREG_W-1:0] unit_dest_o,
  output logic [NUM_UNITS-1:0]        unit_valid_o,
  input  logic [NUM_UNITS-1:0]        unit_ready_i,
  output logic                        illegal_o,
  output logic [NUM_UNITS*CNT_W-1:0]  stall_cnt_o
);

  localparam int SEL_N = 1 << UNIT_W;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [OPC_W-1:0]  opc;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] dest;
  } uop_t;

  logic                 unused_spare;
  logic [UNIT_W-1:0]    sel;
  logic [SEL_N-1:0]     legal_vec;
  logic [SEL_N-1:0]     free_vec;
  logic [NUM_UNITS-1:0] slot_free;
  logic                 accept;
  logic                 illegal_q;
  uop_t                 uop_in;

  // Micro-op field extraction feeds the instruction RAM and register file.
  assign rob_o        = data_i[ROB_W-1:0];
  assign unused_spare = data_i[ROB_W];
  assign rs1_o        = data_i[ROB_W+1 +: PREG_W];
  assign rs2_o        = data_i[ROB_W+1+PREG_W +: PREG_W];

  // With a single unit the selector is meaningless and forced to slot 0.
  assign sel = (NUM_UNITS == 1) ? '0 : unit_i;

  // Selector space padded to a power of two so out-of-range codes index
  // safely; legal_vec marks which codes name a real unit.
  always_comb begin
    legal_vec = '0;
    free_vec  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      legal_vec[i] = 1'b1;
      free_vec[i]  = slot_free[i];
    end
  end

  // Illegal targets are always accepted so they can be dropped and reported.
  assign ready_o = !flush_i & (!legal_vec[sel] | free_vec[sel]);
  assign accept  = valid_i & ready_o;

  always_comb begin
    uop_in      = '0;
    uop_in.a    = lui_i ? '0 : rs1_data_i;
    uop_in.b    = (imm_i | lui_i) ? immediate_i : rs2_data_i;
    uop_in.opc  = lui_i ? OPC_W'(LUI_OPC) : opcode_i;
    uop_in.rob  = rob_o;
    uop_in.dest = dest_i;
  end

  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_reset_ni) illegal_q <= 1'b0;
    else               illegal_q <= accept & !legal_vec[sel];
  end
  assign illegal_o = illegal_q;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_slot
    uop_t q;
    logic hit;

    assign hit = (sel == UNIT_W'(k));

    dispatch_slot #(
      .uop_t (uop_t),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (cpu_clock_i),
      .rst_n     (cpu_reset_ni),
      .flush     (flush_i),
      .load      (accept & hit),
      .uop_in    (uop_in),
      .consume   (unit_ready_i[k]),
      .req       (valid_i & !flush_i & hit),
      .uop_out   (q),
      .valid     (unit_valid_o[k]),
      .free      (slot_free[k]),
      .stall_cnt (stall_cnt_o[k*CNT_W +: CNT_W])
    );

    assign unit_a_o[k*XLEN +: XLEN]       = q.a;
    assign unit_b_o[k*XLEN +: XLEN]       = q.b;
    assign unit_opc_o[k*OPC_W +: OPC_W]   = q.opc;
    assign unit_rob_o[k*ROB_W +: ROB_W]   = q.rob;
    assign unit_dest_o[k*PREG_W +: PREG_W] = q.dest;
  end

endmodule

// File: tb/tb_dispatch_operand_stage.sv
// Directed bench for dispatch_operand_stage: a 2-unit instance for operand
// forming, stall, back-to-back and flush, and a 3-unit instance with a 2-bit
// stall counter for the illegal-unit trap, saturation and mid-stream reset.
module tb_dispatch_operand_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, valid2, valid3, imm, lui;
  logic [17:0] data;
  logic [31:0] rs1d, rs2d, immv;
  logic [6:0]  opc;
  logic [5:0]  dest;
  logic [0:0]  u2;
  logic [1:0]  u3;
  logic [1:0]  rdy2;
  logic [2:0]  rdy3;

  logic        ready2, ill2;
  logic [4:0]  rob2;
  logic [5:0]  rs1o2, rs2o2;
  logic [63:0] a2, b2;
  logic [13:0] opc2;
  logic [9:0]  robv2;
  logic [11:0] dest2;
  logic [1:0]  vld2;
  logic [31:0] cnt2;

  logic        ready3, ill3;
  logic [4:0]  rob3;
  logic [5:0]  rs1o3, rs2o3;
  logic [95:0] a3, b3;
  logic [20:0] opc3;
  logic [14:0] robv3;
  logic [17:0] dest3;
  logic [2:0]  vld3;
  logic [5:0]  cnt3;

  dispatch_operand_stage #(.NUM_UNITS(2)) dut2 (
    .cpu_clock_i(clk), .cpu_reset_ni(rst_n), .flush_i(flush), .data_i(data),
    .valid_i(valid2), .ready_o(ready2), .rob_o(rob2), .rs1_o(rs1o2), .rs2_o(rs2o2),
    .rs1_data_i(rs1d), .rs2_data_i(rs2d), .opcode_i(opc), .imm_i(imm),
    .immediate_i(immv), .dest_i(dest), .lui_i(lui), .unit_i(u2),
    .unit_a_o(a2), .unit_b_o(b2), .unit_opc_o(opc2), .unit_rob_o(robv2),
    .unit_dest_o(dest2), .unit_valid_o(vld2), .unit_ready_i(rdy2),
    .illegal_o(ill2), .stall_cnt_o(cnt2)
  );

  dispatch_operand_stage #(.NUM_UNITS(3), .CNT_W(2)) dut3 (
    .cpu_clock_i(clk), .cpu_reset_ni(rst_n), .flush_i(flush), .data_i(data),
    .valid_i(valid3), .ready_o(ready3), .rob_o(rob3), .rs1_o(rs1o3), .rs2_o(rs2o3),
    .rs1_data_i(rs1d), .rs2_data_i(rs2d), .opcode_i(opc), .imm_i(imm),
    .immediate_i(immv), .dest_i(dest), .lui_i(lui), .unit_i(u3),
    .unit_a_o(a3), .unit_b_o(b3), .unit_opc_o(opc3), .unit_rob_o(robv3),
    .unit_dest_o(dest3), .unit_valid_o(vld3), .unit_ready_i(rdy3),
    .illegal_o(ill3), .stall_cnt_o(cnt3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] unit, input logic [4:0] rob, input logic [31:0] r1);
    u2   = unit[0];
    u3   = unit;
    data = {6'd0, 6'd0, 1'b0, rob};
    rs1d = r1;
    rs2d = r1 + 32'd1;
    imm  = 1'b0;
    lui  = 1'b0;
    immv = 32'd0;
    opc  = 7'h33;
    dest = {1'b0, rob} + 6'd1;
  endtask

  typedef struct {
    logic [0:0]  unit;
    logic [4:0]  rob;
    logic [5:0]  dest;
    logic [31:0] r1, r2, immv;
    logic [6:0]  opc;
    logic        imm, lui;
    logic [31:0] ea, eb;
    logic [6:0]  eopc;
    logic [1:0]  evld;
  } vec_t;

  vec_t tbl[4];

  initial begin
    // unit rob dest r1 r2 immv opc imm lui -> a b opc valid
    tbl[0] = '{1'b1, 5'd3, 6'd7,  32'h10,       32'h20,       32'h5,        7'h13, 1'b0, 1'b0,
               32'h10,       32'h20,       7'h13, 2'b10};
    tbl[1] = '{1'b0, 5'd1, 6'd8,  32'hAAAA,     32'hBBBB,     32'h12345000, 7'h33, 1'b0, 1'b1,
               32'h0,        32'h12345000, 7'h00, 2'b01};
    tbl[2] = '{1'b1, 5'd2, 6'd9,  32'hDEADBEEF, 32'h1,        32'hFFFFF800, 7'h13, 1'b1, 1'b0,
               32'hDEADBEEF, 32'hFFFFF800, 7'h13, 2'b10};
    tbl[3] = '{1'b0, 5'd4, 6'd10, 32'h7FFFFFFF, 32'h80000000, 32'h1,        7'h33, 1'b0, 1'b0,
               32'h7FFFFFFF, 32'h80000000, 7'h33, 2'b01};

    rst_n = 1'b0; flush = 1'b0; valid2 = 1'b0; valid3 = 1'b0;
    rdy2 = 2'b11; rdy3 = 3'b111;
    drive(2'd0, 5'd0, 32'd0);
    tick(); tick();

    // Reset state
    check("rst_valid", 64'(vld2), 64'd0);
    check("rst_a", a2, 64'd0);
    check("rst_stall", 64'(cnt2), 64'd0);
    check("rst_illegal", 64'(ill2), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 64'(ready2), 64'd1);

    // Field extraction: {rs2=0x15, rs1=0x2A, spare, rob=3}
    data = {6'h15, 6'h2A, 1'b1, 5'd3};
    #1;
    check("rob_o", 64'(rob2), 64'd3);
    check("rs1_o", 64'(rs1o2), 64'h2A);
    check("rs2_o", 64'(rs2o2), 64'h15);

    // Operand forming table
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx  = int'(tbl[i].unit);
      u2   = tbl[i].unit;
      data = {6'd0, 6'd0, 1'b0, tbl[i].rob};
      dest = tbl[i].dest;
      rs1d = tbl[i].r1;
      rs2d = tbl[i].r2;
      immv = tbl[i].immv;
      opc  = tbl[i].opc;
      imm  = tbl[i].imm;
      lui  = tbl[i].lui;
      valid2 = 1'b1;
      #1;
      check($sformatf("v%0d_ready", i), 64'(ready2), 64'd1);
      tick();
      valid2 = 1'b0;
      check($sformatf("v%0d_valid", i), 64'(vld2), 64'(tbl[i].evld));
      check($sformatf("v%0d_a", i), 64'(a2[idx*32 +: 32]), 64'(tbl[i].ea));
      check($sformatf("v%0d_b", i), 64'(b2[idx*32 +: 32]), 64'(tbl[i].eb));
      check($sformatf("v%0d_opc", i), 64'(opc2[idx*7 +: 7]), 64'(tbl[i].eopc));
      check($sformatf("v%0d_rob", i), 64'(robv2[idx*5 +: 5]), 64'(tbl[i].rob));
      check($sformatf("v%0d_dest", i), 64'(dest2[idx*6 +: 6]), 64'(tbl[i].dest));
    end

    // Stall on unit 0 (still holding vector 3) for 3 cycles, then release
    rdy2 = 2'b10;
    drive(2'd0, 5'd9, 32'h111);
    valid2 = 1'b1;
    #1;
    check("stall_ready", 64'(ready2), 64'd0);
    repeat (3) tick();
    check("stall_ready_held", 64'(ready2), 64'd0);
    check("stall_hold_a", 64'(a2[31:0]), 64'h7FFFFFFF);
    check("stall_hold_rob", 64'(robv2[4:0]), 64'd4);
    check("stall_hold_valid", 64'(vld2), 64'b01);
    check("stall_cnt0", 64'(cnt2[15:0]), 64'd3);
    rdy2 = 2'b11;
    #1;
    check("release_ready", 64'(ready2), 64'd1);
    tick();
    valid2 = 1'b0;
    check("release_a", 64'(a2[31:0]), 64'h111);
    check("release_rob", 64'(robv2[4:0]), 64'd9);
    check("release_cnt0", 64'(cnt2[15:0]), 64'd3);

    // Back-to-back into unit 0 while it is consumed every cycle
    for (int j = 0; j < 3; j++) begin
      drive(2'd0, 5'(10 + j), 32'h200 + 32'(j));
      valid2 = 1'b1;
      #1;
      check($sformatf("b2b%0d_ready", j), 64'(ready2), 64'd1);
      tick();
      check($sformatf("b2b%0d_a", j), 64'(a2[31:0]), 64'h200 + 64'(j));
      check($sformatf("b2b%0d_valid", j), 64'(vld2[0]), 64'd1);
    end
    valid2 = 1'b0;
    tick();
    check("b2b_drain", 64'(vld2), 64'd0);

    // Flush with both slots occupied and an op on offer
    rdy2 = 2'b00;
    drive(2'd0, 5'd20, 32'h300);
    valid2 = 1'b1;
    tick();
    drive(2'd1, 5'd21, 32'h301);
    tick();
    check("pre_flush_valid", 64'(vld2), 64'b11);
    drive(2'd0, 5'd22, 32'h302);
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(ready2), 64'd0);
    tick();
    flush  = 1'b0;
    valid2 = 1'b0;
    check("flush_valid", 64'(vld2), 64'd0);
    check("flush_cnt0", 64'(cnt2[15:0]), 64'd3);
    check("flush_cnt1", 64'(cnt2[31:16]), 64'd0);
    rdy2 = 2'b11;

    // Three units: out-of-range unit 3 is accepted, dropped and flagged
    drive(2'd3, 5'd1, 32'h55);
    valid3 = 1'b1;
    #1;
    check("ill_ready", 64'(ready3), 64'd1);
    tick();
    valid3 = 1'b0;
    check("ill_pulse", 64'(ill3), 64'd1);
    check("ill_no_slot", 64'(vld3), 64'd0);
    tick();
    check("ill_pulse_end", 64'(ill3), 64'd0);

    drive(2'd2, 5'd5, 32'hABC);
    valid3 = 1'b1;
    tick();
    valid3 = 1'b0;
    check("u2_valid", 64'(vld3), 64'b100);
    check("u2_a", 64'(a3[95:64]), 64'hABC);
    check("u2_no_illegal", 64'(ill3), 64'd0);

    // Stall counter saturates at all-ones (2-bit counter, 5 blocked cycles)
    rdy3 = 3'b011;
    drive(2'd2, 5'd6, 32'hDEF);
    valid3 = 1'b1;
    #1;
    check("sat_ready", 64'(ready3), 64'd0);
    repeat (5) tick();
    check("sat_cnt2", 64'(cnt3[5:4]), 64'd3);
    check("sat_hold_a", 64'(a3[95:64]), 64'hABC);

    // Mid-stream reset clears everything
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    valid3 = 1'b0;
    check("mrst_valid3", 64'(vld3), 64'd0);
    check("mrst_a3", 64'(a3[95:64]), 64'd0);
    check("mrst_cnt3", 64'(cnt3), 64'd0);
    check("mrst_ill3", 64'(ill3), 64'd0);
    check("mrst_cnt2", 64'(cnt2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch_operand_stage.md
Name: dispatch_operand_stage

Overview:
- Parametrised register-read/dispatch stage between the issue queue and N execution units. Generalises the fixed ALU/vector-ALU split to NUM_UNITS channels.
- Reads the physical register file, forms operands (LUI zeroing, immediate select), and steers each micro-op to one unit's output register.
- Adds a per-unit valid/ready handshake with hold-on-stall, upstream backpressure, flush kill, an illegal-unit trap and a per-unit stall counter.

Parameters:
- XLEN, 32, operand width
- PREG_W, 6, physical register index width
- ROB_W, 5, ROB id width
- OPC_W, 7, opcode width
- NUM_UNITS, 2, execution channels (>=1)
- LUI_OPC, 0, opcode forced for LUI (ADD)
- CNT_W, 16, stall counter width

Ports:
- cpu_clock_i, in, 1, core clock
- cpu_reset_ni, in, 1, synchronous active-low reset
- flush_i, in, 1, pipeline flush
- data_i, in, ROB_W+1+2*PREG_W, {rs2, rs1, spare, rob}; rob=[ROB_W-1:0], rs1 starts at ROB_W+1
- valid_i, in, 1, micro-op offered
- ready_o, out, 1, micro-op accepted this cycle when valid_i&ready_o
- rob_o, out, ROB_W, rob field to instruction RAM (combinational)
- rs1_o / rs2_o, out, PREG_W, register file read addresses (combinational)
- rs1_data_i / rs2_data_i, in, XLEN, same-cycle read data
- opcode_i, in, OPC_W, from instruction RAM
- imm_i, in, 1, operand B = immediate
- immediate_i, in, XLEN, immediate
- dest_i, in, PREG_W, destination preg
- lui_i, in, 1, LUI micro-op
- unit_i, in, max(1,$clog2(NUM_UNITS)), target unit
- unit_a_o, out, NUM_UNITS*XLEN, operand A per unit
- unit_b_o, out, NUM_UNITS*XLEN, operand B per unit
- unit_opc_o, out, NUM_UNITS*OPC_W, opcode per unit
- unit_rob_o, out, NUM_UNITS*ROB_W, ROB id per unit
- unit_dest_o, out, NUM_UNITS*PREG_W, destination per unit
- unit_valid_o, out, NUM_UNITS, slot valid
- unit_ready_i, in, NUM_UNITS, unit consumes slot
- illegal_o, out, 1, one-cycle pulse: accepted op had unit_i>=NUM_UNITS
- stall_cnt_o, out, NUM_UNITS*CNT_W, cycles unit k blocked upstream

Behaviour:
- Reset (cpu_reset_ni=0 at clock edge): all unit_valid_o=0, all data outputs=0, illegal_o=0, stall_cnt_o=0. Reset has priority over flush and all other activity.
- Operand forming:
  - A = lui_i ? 0 : rs1_data_i
  - B = (imm_i|lui_i) ? immediate_i : rs2_data_i
  - opc = lui_i ? LUI_OPC : opcode_i
- Slot k is free when !unit_valid_o[k] | unit_ready_i[k].
- ready_o = !flush_i & (unit_i>=NUM_UNITS | slot[unit_i] free). It is combinational from unit_i/unit_ready_i.
- Accept (valid_i&ready_o), legal unit: slot k=unit_i loads A, B, opc, rob, dest and sets valid=1 next cycle. Latency 1 cycle.
- Slot k with valid&unit_ready_i[k] and no new load: valid goes to 0.
- Simultaneous consume and load on the same slot: the new op replaces the old one; valid stays 1.
- Hold: while valid&!unit_ready_i[k], all slot-k outputs are stable.
- Illegal unit: the op is accepted and dropped; illegal_o=1 for the next cycle; no slot changes.
- Flush: all unit_valid_o=0 at the next edge, including ops offered in the flush cycle. ready_o=0 during flush. Data registers may retain values. stall_cnt_o is unaffected.
- Stall counter k increments when valid_i & !flush_i & unit_i==k & slot k not free. It saturates at all-ones.
- NUM_UNITS=1: unit_i is ignored (treated as 0); illegal_o is never asserted.

Decomposition:
- Shared package (core_pkg): dispatch_uop_t struct {a, b, opc, rob, dest}, width localparams, LUI_OPC default.
- One sub-module, dispatch_slot: a single output register with valid/ready, hold, flush and a saturating stall counter. Instantiated NUM_UNITS times via generate.

Test Plan:
- Reset, then op rob=3, rs1 data=0x10, rs2 data=0x20, imm_i=0, unit_i=1 -> cycle+1: unit_valid_o=2'b10, a=0x10, b=0x20, rob=3.
- lui_i=1, immediate_i=0x12345000, opcode_i=0x33 -> a=0, b=0x12345000, opc=0.
- Unit 0 valid with unit_ready_i[0]=0 held 3 cycles, new op to unit 0 -> ready_o=0, outputs stable, stall_cnt[0]=3. Release -> new op loads the following cycle.
- Back-to-back ops to unit 0 with unit_ready_i[0]=1 each cycle -> one op per cycle, valid held 1, no bubble.
- flush_i with both slots valid and an op offered -> ready_o=0; next cycle unit_valid_o=0.
- NUM_UNITS=3, unit_i=3 -> op accepted, illegal_o pulse; mid-stream cpu_reset_ni=0 -> all outputs 0 next edge.
